// File: rtl/maxpool_stream.sv
`default_nettype none
// ============================================================================
// maxpool_stream : streaming 2x2 max-pool (stride 1 or 2) or bypass of conv
//                  output tiles, SYSTOLIC_SIZE signed lanes per beat.
// Revision       : 1.0
// ============================================================================
module maxpool_stream #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_ROW_SIZE  = 512
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [8:0]                          ofm_size_conv,
  input  logic                                maxpool_mode,
  input  logic [1:0]                          maxpool_stride,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] out_data,
  output logic                                busy,
  output logic                                done
);

  localparam int LW = SYSTOLIC_SIZE * DATA_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_EDGE  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [8:0]    n_q, n_d, row_q, row_d, col_q, col_d;
  logic          pool_q, pool_d, s1_q, s1_d;
  logic [LW-1:0] hold_q, hold_d, prev_q, prev_d;
  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] out_data_q, out_data_d;

  logic [LW-1:0] linebuf_q [MAX_ROW_SIZE];
  logic          lb_we;
  logic [8:0]    lb_waddr;
  logic [LW-1:0] lb_wdata;
  logic [LW-1:0] lb_rd0, lb_rdm1, lb_rdp1, lb_rdn1;

  logic          can_load, load, last_ev, col_last, row_last;
  logic [LW-1:0] load_data;

  function automatic logic [LW-1:0] vmax(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW-1:0] r;
    for (int k = 0; k < SYSTOLIC_SIZE; k++) begin
      r[k*DATA_WIDTH +: DATA_WIDTH] =
        ($signed(a[k*DATA_WIDTH +: DATA_WIDTH]) > $signed(b[k*DATA_WIDTH +: DATA_WIDTH])) ?
        a[k*DATA_WIDTH +: DATA_WIDTH] : b[k*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  assign can_load = !out_valid_q || out_ready;
  assign col_last = (col_q == n_q - 9'd1);
  assign row_last = (row_q == n_q - 9'd1);
  assign lb_rd0   = linebuf_q[col_q];
  assign lb_rdm1  = linebuf_q[col_q - 9'd1];
  assign lb_rdp1  = linebuf_q[col_q + 9'd1];
  assign lb_rdn1  = linebuf_q[n_q - 9'd1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pool_q      <= 1'b0;
      s1_q        <= 1'b0;
      hold_q      <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pool_q      <= pool_d;
      s1_q        <= s1_d;
      hold_q      <= hold_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_waddr] <= lb_wdata;
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    pool_d      = pool_q;
    s1_d        = s1_q;
    hold_d      = hold_q;
    prev_d      = prev_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lb_we       = 1'b0;
    lb_waddr    = col_q;
    lb_wdata    = in_data;
    load        = 1'b0;
    load_data   = in_data;
    last_ev     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        n_d     = ofm_size_conv;
        pool_d  = maxpool_mode;
        s1_d    = (maxpool_stride == 2'd1);
        row_d   = '0;
        col_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: if (in_valid && can_load) begin
        col_d = col_last ? 9'd0 : col_q + 9'd1;
        if (col_last) row_d = row_q + 9'd1;
        if (!pool_q) begin
          load    = 1'b1;
          last_ev = col_last && row_last;
        end else if (!s1_q) begin
          if (!row_q[0]) lb_we = 1'b1;
          else if (!col_q[0]) hold_d = vmax(lb_rd0, in_data);
          else begin
            load      = 1'b1;
            load_data = vmax(hold_q, vmax(lb_rd0, in_data));
          end
          last_ev = col_last && row_last;
        end else begin
          prev_d = in_data;
          if (row_q == 9'd0) lb_we = 1'b1;
          else if (col_q != 9'd0) begin
            // window (r-1,c-1); linebuf[c-1] is retired to the current row here
            load      = 1'b1;
            load_data = vmax(vmax(lb_rdm1, lb_rd0), vmax(prev_q, in_data));
            lb_we     = 1'b1;
            lb_waddr  = col_q - 9'd1;
            lb_wdata  = prev_q;
          end
          if (col_last && row_q != 9'd0) state_d = S_EDGE;
          else if (col_last && row_last) state_d = S_FLUSH;
        end
      end
      S_EDGE: if (can_load) begin
        load      = 1'b1;
        load_data = vmax(lb_rdn1, prev_q);
        lb_we     = 1'b1;
        lb_waddr  = n_q - 9'd1;
        lb_wdata  = prev_q;
        state_d   = (row_q == n_q) ? S_FLUSH : S_RUN;
      end
      S_FLUSH: if (can_load) begin
        load      = 1'b1;
        load_data = col_last ? lb_rd0 : vmax(lb_rd0, lb_rdp1);
        col_d     = col_q + 9'd1;
        last_ev   = col_last;
      end
      S_DRAIN: if (out_valid_q && out_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (last_ev) state_d = (load || (out_valid_q && !out_ready)) ? S_DRAIN : S_DONE;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    in_ready = (state_q == S_RUN) && can_load;
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    done     = (state_q == S_DONE);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_stream.sv
`default_nettype none
// Testbench for maxpool_stream: scoreboard of model-derived pooled beats.
module tb_maxpool_stream;
  localparam int SYS = 16;
  localparam int DW  = 16;
  localparam int LW  = SYS * DW;

  logic          clk = 1'b0;
  logic          rst, start, maxpool_mode, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [8:0]    ofm_size_conv;
  logic [1:0]    maxpool_stride;
  logic [LW-1:0] in_data, out_data;

  maxpool_stream #(.SYSTOLIC_SIZE(SYS), .DATA_WIDTH(DW), .MAX_ROW_SIZE(512)) dut (
    .clk(clk), .rst(rst), .start(start), .ofm_size_conv(ofm_size_conv),
    .maxpool_mode(maxpool_mode), .maxpool_stride(maxpool_stride),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] img [SYS][64];
  logic [LW-1:0] q_exp[$];
  logic [LW-1:0] q_got[$];
  int n_checks = 0, n_fail = 0;
  int done_cnt, done_cyc, last_acc_cyc, last_in_cyc, stable_err, in_stalls, timeout;
  logic busy_first;

  function automatic logic [LW-1:0] pixvec(input int i);
    logic [LW-1:0] v;
    for (int k = 0; k < SYS; k++) v[k*DW +: DW] = img[k][i];
    return v;
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reference: direct 2x2 windows over the image, clamped at the edges for stride 1.
  task automatic push_expected(input int n, input logic mode, input logic [1:0] stride);
    logic [LW-1:0] v;
    logic signed [DW-1:0] m;
    int rr, cc;
    if (!mode) begin
      for (int i = 0; i < n*n; i++) q_exp.push_back(pixvec(i));
    end else if (stride != 2'd1) begin
      for (int r = 0; r < n/2; r++)
        for (int c = 0; c < n/2; c++) begin
          for (int k = 0; k < SYS; k++) begin
            m = img[k][2*r*n + 2*c];
            m = smax(m, img[k][2*r*n + 2*c + 1]);
            m = smax(m, img[k][(2*r+1)*n + 2*c]);
            m = smax(m, img[k][(2*r+1)*n + 2*c + 1]);
            v[k*DW +: DW] = m;
          end
          q_exp.push_back(v);
        end
    end else begin
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          for (int k = 0; k < SYS; k++) begin
            m = img[k][r*n + c];
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                rr = (r + dr > n - 1) ? n - 1 : r + dr;
                cc = (c + dc > n - 1) ? n - 1 : c + dc;
                m = smax(m, img[k][rr*n + cc]);
              end
            v[k*DW +: DW] = m;
          end
          q_exp.push_back(v);
        end
    end
  endtask

  task automatic fill_img(input int n, input int kind);
    for (int i = 0; i < n*n; i++)
      for (int k = 0; k < SYS; k++) begin
        if (kind == 0 || k == 0) img[k][i] = DW'(i);
        else if (k == 1)         img[k][i] = -DW'(i);
        else                     img[k][i] = DW'($urandom);
      end
  endtask

  task automatic drive_frame(input int n, input logic mode, input logic [1:0] stride,
                             input int vpct, input int rpct);
    q_exp.delete(); q_got.delete();
    push_expected(n, mode, stride);
    done_cnt = 0; done_cyc = -1; last_acc_cyc = 0; last_in_cyc = 0;
    stable_err = 0; in_stalls = 0; timeout = 0;
    @(posedge clk); #1;
    start = 1'b1; ofm_size_conv = 9'(n); maxpool_mode = mode; maxpool_stride = stride;
    @(posedge clk); #1;
    start = 1'b0; ofm_size_conv = 9'd0; maxpool_mode = 1'b0; maxpool_stride = 2'd0;
    busy_first = busy;
    fork
      begin
        int i, g;
        logic hs;
        i = 0; g = 0;
        while (i < n*n && g < 4000) begin
          in_valid = ($urandom_range(99) < vpct);
          in_data  = pixvec(i);
          @(negedge clk);
          hs = in_valid && in_ready;
          if (in_valid && !in_ready) in_stalls++;
          if (hs) last_in_cyc = cyc;
          @(posedge clk); #1;
          if (hs) i++;
          g++;
        end
        in_valid = 1'b0;
        if (g >= 4000) timeout = 1;
      end
      begin
        int g, extra;
        logic stalled;
        logic [LW-1:0] last_d;
        g = 0; extra = -1; stalled = 1'b0; last_d = '0;
        while (extra != 0 && g < 4000) begin
          out_ready = ($urandom_range(99) < rpct);
          @(negedge clk);
          if (stalled && out_data !== last_d) stable_err++;
          if (out_valid && out_ready) begin q_got.push_back(out_data); last_acc_cyc = cyc; end
          stalled = out_valid && !out_ready;
          last_d  = out_data;
          if (done) begin done_cnt++; done_cyc = cyc; if (extra < 0) extra = 4; end
          if (extra > 0) extra--;
          @(posedge clk); #1;
          g++;
        end
        out_ready = 1'b1;
        if (g >= 4000) timeout = 1;
      end
    join
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    ofm_size_conv = 9'd0; maxpool_mode = 1'b0; maxpool_stride = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_frame(input string name, input int n, input logic mode, input logic [1:0] stride,
                            input int kind, input int vpct, input int rpct, input int exp_stalls);
    int exp_done;
    fill_img(n, kind);
    drive_frame(n, mode, stride, vpct, rpct);
    exp_done = ((last_acc_cyc > last_in_cyc) ? last_acc_cyc : last_in_cyc) + 1;
    n_checks++;
    if (q_got.size() != q_exp.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d beats expected %0d", name, q_got.size(), q_exp.size());
    end
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      n_checks++;
      if (q_got[i] !== q_exp[i]) begin
        n_fail++; $display("FAIL %s_data[%0d]: got %h expected %h", name, i, q_got[i], q_exp[i]);
      end
    end
    n_checks++;
    if (timeout != 0 || done_cnt != 1 || done_cyc != exp_done) begin
      n_fail++; $display("FAIL %s_done: got %0d pulses at cycle %0d (timeout %0d) expected 1 at cycle %0d",
                         name, done_cnt, done_cyc, timeout, exp_done);
    end
    n_checks++;
    if (busy_first !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got first %b final %b expected 1 then 0", name, busy_first, busy);
    end
    n_checks++;
    if (stable_err != 0) begin
      n_fail++; $display("FAIL %s_stable: got %0d changes while stalled expected 0", name, stable_err);
    end
    if (exp_stalls >= 0) begin
      n_checks++;
      if (in_stalls != exp_stalls) begin
        n_fail++; $display("FAIL %s_in_stalls: got %0d expected %0d", name, in_stalls, exp_stalls);
      end
    end
  endtask

  task automatic test_bypass;         test_frame("bypass",    4, 1'b0, 2'd2, 0, 100, 100, 0); endtask
  task automatic test_stride2;        test_frame("stride2",   4, 1'b1, 2'd2, 1, 100, 100, 0); endtask
  task automatic test_stride2_odd;    test_frame("stride2n5", 5, 1'b1, 2'd2, 0, 100, 100, 0); endtask
  task automatic test_stride1;        test_frame("stride1",   3, 1'b1, 2'd1, 0, 100, 100, 1); endtask
  task automatic test_backpressure;   test_frame("backpress", 4, 1'b1, 2'd2, 1, 100, 30, -1); endtask
  task automatic test_random;
    test_frame("stride1rnd", 5, 1'b1, 2'd1, 1, 70, 60, -1);
    test_frame("stride3rnd", 6, 1'b1, 2'd3, 1, 70, 60, -1);
    test_frame("s1n1",       1, 1'b1, 2'd1, 1, 100, 100, 0);
    test_frame("s2n1",       1, 1'b1, 2'd2, 1, 100, 100, 0);
  endtask

  task automatic test_reset_mid;
    fill_img(4, 0);
    @(posedge clk); #1;
    start = 1'b1; ofm_size_conv = 9'd4; maxpool_mode = 1'b1; maxpool_stride = 2'd2;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = pixvec(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle: got valid %b busy %b ready %b done %b expected all 0",
                         out_valid, busy, in_ready, done);
    end
    for (int k = 0; k < SYS; k++) begin
      img[k][0] = 16'sd1; img[k][1] = -16'sd3; img[k][2] = 16'sd7; img[k][3] = 16'sd2;
    end
    drive_frame(2, 1'b1, 2'd2, 100, 100);
    n_checks++;
    if (q_got.size() != 1 || q_exp.size() != 1) begin
      n_fail++; $display("FAIL rstmid_count: got %0d beats expected 1", q_got.size());
    end else begin
      n_checks++;
      if (q_got[0] !== q_exp[0] || q_got[0][DW-1:0] !== 16'd7) begin
        n_fail++; $display("FAIL rstmid_data: got %h expected %h", q_got[0], q_exp[0]);
      end
    end
    n_checks++;
    if (done_cnt != 1 || timeout != 0) begin
      n_fail++; $display("FAIL rstmid_done: got %0d pulses (timeout %0d) expected 1", done_cnt, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stride2();
    test_stride2_odd();
    test_stride1();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
